sysarr_feeder: RTL and testbench

- Transmit-side companion to the 3x3 IEEE-754 single-precision systolic array.
- Holds one A matrix and one B matrix, each N x N, loaded by a simple write port.
- On start, drives the skewed row and column wavefronts into the array's west (A) and north (B) edges.
- After the wavefronts, drives zero flush beats so the array drains, then pulses done.

---
 rtl/sysarr_feeder.sv | 140 ++++++++++++++
 tb/tb_sysarr_feeder.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/sysarr_feeder.sv
// Streams a stored N x N A and B pair into a systolic array as skewed west/north
// wavefronts, follows them with all-zero flush beats, then pulses done.
module sysarr_feeder #(
  parameter int unsigned N     = 3,
  parameter int unsigned W     = 32,
  parameter int unsigned AW    = 4,
  parameter int unsigned FLUSH = 6,
  parameter int unsigned CW    = 5
) (
  input  logic           clock,
  input  logic           reset,
  input  logic           wr_en,
  input  logic           wr_sel,
  input  logic [AW-1:0]  wr_addr,
  input  logic [W-1:0]   wr_data,
  input  logic           start,
  output logic [N*W-1:0] a_out,
  output logic [N*W-1:0] b_out,
  output logic           out_valid,
  output logic           busy,
  output logic           done
);

  localparam int unsigned NN        = N * N;
  localparam int unsigned LAST_BEAT = 2 * N - 2;

  typedef enum logic [1:0] {
    S_IDLE,
    S_STREAM,
    S_FLUSH,
    S_DONE
  } state_t;

  state_t         r_state, w_state_nx;
  logic [CW-1:0]  r_cnt, w_cnt_nx;
  logic [W-1:0]   r_a [NN];
  logic [W-1:0]   r_b [NN];
  logic [N*W-1:0] r_a_out, r_b_out, w_a_nx, w_b_nx, w_a_beat, w_b_beat;
  logic           r_valid, r_busy, r_done, w_valid_nx, w_done_nx, w_wr_ok;

  assign w_wr_ok = (r_state == S_IDLE) && wr_en && ({1'b0, wr_addr} < (AW+1)'(NN));

  // Skewed wavefront for beat r_cnt: lane i carries element (t - i) of its row/column.
  always_comb begin
    w_a_beat = '0;
    w_b_beat = '0;
    for (int i = 0; i < int'(N); i++) begin
      if (int'(r_cnt) >= i && int'(r_cnt) - i < int'(N)) begin
        w_a_beat[i*W +: W] = r_a[AW'(i * int'(N) + int'(r_cnt) - i)];
        w_b_beat[i*W +: W] = r_b[AW'((int'(r_cnt) - i) * int'(N) + i)];
      end
    end
  end

  always_comb begin
    w_state_nx = r_state;
    w_cnt_nx   = r_cnt;
    w_a_nx     = '0;
    w_b_nx     = '0;
    w_valid_nx = 1'b0;
    w_done_nx  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_state_nx = S_STREAM;
          w_cnt_nx   = '0;
        end
      end
      S_STREAM: begin
        w_a_nx     = w_a_beat;
        w_b_nx     = w_b_beat;
        w_valid_nx = 1'b1;
        if (r_cnt == CW'(LAST_BEAT)) begin
          w_state_nx = S_FLUSH;
          w_cnt_nx   = '0;
        end else begin
          w_cnt_nx = r_cnt + CW'(1);
        end
      end
      S_FLUSH: begin
        // Count FLUSH zero beats; the edge after the last one registers done.
        if (r_cnt == CW'(FLUSH)) begin
          w_done_nx  = 1'b1;
          w_state_nx = S_DONE;
          w_cnt_nx   = '0;
        end else begin
          w_valid_nx = 1'b1;
          w_cnt_nx   = r_cnt + CW'(1);
        end
      end
      S_DONE: begin
        w_state_nx = S_IDLE;
      end
      default: begin
        w_state_nx = S_IDLE;
        w_cnt_nx   = '0;
      end
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_a_out <= '0;
      r_b_out <= '0;
      r_valid <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nx;
      r_cnt   <= w_cnt_nx;
      r_a_out <= w_a_nx;
      r_b_out <= w_b_nx;
      r_valid <= w_valid_nx;
      r_busy  <= (w_state_nx != S_IDLE);
      r_done  <= w_done_nx;
    end
  end

  // Matrix storage; writable only while idle.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < int'(NN); i++) begin
        r_a[i] <= '0;
        r_b[i] <= '0;
      end
    end else if (w_wr_ok) begin
      if (wr_sel) r_b[wr_addr] <= wr_data;
      else        r_a[wr_addr] <= wr_data;
    end
  end

  assign a_out     = r_a_out;
  assign b_out     = r_b_out;
  assign out_valid = r_valid;
  assign busy      = r_busy;
  assign done      = r_done;

endmodule

// File: tb/tb_sysarr_feeder.sv
// Bench for sysarr_feeder: a stream-offset reference model checked every cycle,
// plus literal expectations for the skew, framing, write-gating and reset cases.
module tb_sysarr_feeder;
  localparam int N = 3, W = 32, AW = 4, FLUSH = 6, CW = 5;
  localparam int NN = N * N, TOT = 2 * N + FLUSH, LOGN = 16;

  logic           clock = 1'b0, reset = 1'b1;
  logic           wr_en = 1'b0, wr_sel = 1'b0, start = 1'b0;
  logic [AW-1:0]  wr_addr = '0;
  logic [W-1:0]   wr_data = '0;
  logic [N*W-1:0] a_out, b_out;
  logic           out_valid, busy, done;

  sysarr_feeder #(.N(N), .W(W), .AW(AW), .FLUSH(FLUSH), .CW(CW)) dut (
    .clock(clock), .reset(reset), .wr_en(wr_en), .wr_sel(wr_sel),
    .wr_addr(wr_addr), .wr_data(wr_data), .start(start),
    .a_out(a_out), .b_out(b_out), .out_valid(out_valid), .busy(busy), .done(done)
  );

  always #5 clock = ~clock;

  int checks = 0, failures = 0;

  // Reference model: matrix contents plus the edge index at which the current stream started.
  logic [W-1:0] m_a [NN];
  logic [W-1:0] m_b [NN];
  logic [W-1:0] s_a [NN];
  logic [W-1:0] s_b [NN];
  int m_n = 0, m_e0 = 0;
  bit m_active = 1'b0;
  int e0_q[$];

  always @(posedge clock or posedge reset) begin
    bit idle_before;
    if (reset) begin
      for (int i = 0; i < NN; i++) begin m_a[i] = '0; m_b[i] = '0; end
      m_active = 1'b0;
      m_n = 0;
    end else begin
      m_n++;
      idle_before = !m_active || (m_n - 1 - m_e0) > TOT;
      if (idle_before) begin
        if (wr_en && int'(wr_addr) < NN) begin
          if (wr_sel) m_b[wr_addr] = wr_data;
          else        m_a[wr_addr] = wr_data;
        end
        if (start) begin
          m_active = 1'b1;
          m_e0 = m_n;
          for (int i = 0; i < NN; i++) begin s_a[i] = m_a[i]; s_b[i] = m_b[i]; end
          e0_q.push_back(m_n);
        end
      end
    end
  end

  function automatic bit model_busy();
    return m_active && (m_n - m_e0) <= TOT;
  endfunction

  function automatic logic [W-1:0] lane(input logic [N*W-1:0] v, input int i);
    return v[i*W +: W];
  endfunction

  logic [N*W-1:0] log_a [LOGN];
  logic [N*W-1:0] log_b [LOGN];
  logic           log_v [LOGN];
  logic           log_d [LOGN];
  logic           log_bz [LOGN];
  int             valid_total = 0;

  task automatic chk(input string name, input logic [N*W-1:0] act, input logic [N*W-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle comparison of every output against the model, plus logging of the current stream.
  task automatic cmp();
    logic [N*W-1:0] ea, eb;
    bit ev, ebz, ed;
    int d, t, k;
    ea = '0; eb = '0; ev = 0; ebz = 0; ed = 0; d = 0;
    if (!reset && m_active) begin
      d = m_n - m_e0;
      t = d - 1;
      ebz = (d <= TOT);
      ev  = (d >= 1 && d <= 2 * N - 1 + FLUSH);
      ed  = (d == TOT);
      if (t >= 0 && t <= 2 * N - 2) begin
        for (int i = 0; i < N; i++) begin
          k = t - i;
          if (k >= 0 && k < N) begin
            ea[i*W +: W] = s_a[i * N + k];
            eb[i*W +: W] = s_b[k * N + i];
          end
        end
      end
    end
    chk("a_out", a_out, ea);
    chk("b_out", b_out, eb);
    chk("out_valid", N*W'(out_valid), N*W'(ev));
    chk("busy", N*W'(busy), N*W'(ebz));
    chk("done", N*W'(done), N*W'(ed));
    if (out_valid) valid_total++;
    if (!reset && m_active && d < LOGN) begin
      if (d == 0)
        for (int i = 0; i < LOGN; i++) begin
          log_a[i] = '0; log_b[i] = '0; log_v[i] = 0; log_d[i] = 0; log_bz[i] = 0;
        end
      log_a[d] = a_out; log_b[d] = b_out; log_v[d] = out_valid;
      log_d[d] = done;  log_bz[d] = busy;
    end
  endtask

  task automatic cyc();
    @(negedge clock);
    cmp();
    @(posedge clock);
    #1;
  endtask

  task automatic wr(input bit sel, input int addr, input logic [W-1:0] data);
    wr_sel = sel; wr_addr = AW'(addr); wr_data = data; wr_en = 1'b1;
    cyc();
    wr_en = 1'b0;
  endtask

  // Pulses start (alongside any write already set up), then waits for the stream to end.
  task automatic run_stream(input bit mid_wr);
    int c;
    start = 1'b1;
    cyc();
    start = 1'b0;
    wr_en = 1'b0;
    c = 0;
    while (model_busy() && c < 40) begin
      if (mid_wr && c == 2) begin
        wr_sel = 1'b0; wr_addr = '0; wr_data = 32'h4040_0000; wr_en = 1'b1;
      end else begin
        wr_en = 1'b0;
      end
      cyc();
      c++;
    end
    wr_en = 1'b0;
    if (model_busy()) begin
      checks++; failures++;
      $display("FAIL stream_timeout: still busy after %0d cycles", c);
    end
    cyc();
  endtask

  logic [W-1:0] fl [NN];
  int cnt_v, cnt_d, cnt_nz, q0;

  initial begin
    fl = '{32'h3F80_0000, 32'h4000_0000, 32'h4040_0000,
           32'h4080_0000, 32'h40A0_0000, 32'h40C0_0000,
           32'h40E0_0000, 32'h4100_0000, 32'h4110_0000};
    #1;
    chk("rst_a_out", a_out, '0);
    chk("rst_busy", N*W'(busy), '0);
    cyc(); cyc();
    reset = 1'b0;
    cyc();

    // Skew: A[i][k] = 3i+k+1, B = identity
    for (int i = 0; i < NN; i++) wr(1'b0, i, fl[i]);
    for (int j = 0; j < N; j++) wr(1'b1, j * N + j, 32'h3F80_0000);
    run_stream(1'b0);
    chk("t1_b0_a0", N*W'(lane(log_a[1], 0)), N*W'(32'h3F80_0000));
    chk("t1_b0_a12", N*W'(log_a[1][N*W-1:W]), '0);
    chk("t1_b1_a1", N*W'(lane(log_a[2], 1)), N*W'(32'h4080_0000));
    chk("t1_b4_a2", N*W'(lane(log_a[5], 2)), N*W'(32'h4110_0000));
    chk("t1_b4_a01", N*W'(log_a[5][2*W-1:0]), '0);
    for (int j = 0; j < N; j++) begin
      cnt_nz = 0;
      for (int d = 1; d <= 2 * N - 1; d++) if (lane(log_b[d], j) != 0) cnt_nz++;
      chk("t1_b_nonzero_cnt", N*W'(cnt_nz), N*W'(1));
      chk("t1_b_diag", N*W'(lane(log_b[2 * j + 1], j)), N*W'(32'h3F80_0000));
    end

    // Framing
    cnt_v = 0; cnt_d = 0;
    for (int d = 0; d < LOGN; d++) begin
      if (log_v[d]) cnt_v++;
      if (log_d[d]) cnt_d++;
    end
    chk("t2_valid_beats", N*W'(cnt_v), N*W'(11));
    chk("t2_done_pulses", N*W'(cnt_d), N*W'(1));
    chk("t2_done_at_e12", N*W'(log_d[12]), N*W'(1));
    chk("t2_busy_e0", N*W'(log_bz[0]), N*W'(1));
    chk("t2_busy_e12", N*W'(log_bz[12]), N*W'(1));
    chk("t2_busy_e13", N*W'(log_bz[13]), '0);

    // Writes while busy and out-of-range writes are discarded
    run_stream(1'b1);
    run_stream(1'b0);
    chk("t3_busy_wr_ignored", N*W'(lane(log_a[1], 0)), N*W'(32'h3F80_0000));
    wr(1'b0, 9, 32'hDEAD_BEEF);
    wr(1'b1, 15, 32'hDEAD_BEEF);
    run_stream(1'b0);
    chk("t3_oob_a00", N*W'(lane(log_a[1], 0)), N*W'(32'h3F80_0000));
    chk("t3_oob_a22", N*W'(lane(log_a[5], 2)), N*W'(32'h4110_0000));

    // Write and start on the same edge
    wr_sel = 1'b0; wr_addr = '0; wr_data = 32'h40A0_0000; wr_en = 1'b1;
    run_stream(1'b0);
    chk("t4_same_edge", N*W'(lane(log_a[1], 0)), N*W'(32'h40A0_0000));

    // Asynchronous reset mid-stream
    start = 1'b1; cyc(); start = 1'b0;
    for (int i = 0; i < 4; i++) cyc();
    #1 reset = 1'b1;
    #1;
    chk("t5_rst_a_out", a_out, '0);
    chk("t5_rst_b_out", b_out, '0);
    chk("t5_rst_valid", N*W'(out_valid), '0);
    chk("t5_rst_busy", N*W'(busy), '0);
    chk("t5_rst_done", N*W'(done), '0);
    cyc(); cyc();
    reset = 1'b0;
    cyc(); cyc(); cyc();
    run_stream(1'b0);
    cnt_nz = 0; cnt_v = 0;
    for (int d = 0; d < LOGN; d++) begin
      if (log_a[d] != 0 || log_b[d] != 0) cnt_nz++;
      if (log_v[d]) cnt_v++;
    end
    chk("t5_lanes_zero", N*W'(cnt_nz), '0);
    chk("t5_valid_beats", N*W'(cnt_v), N*W'(11));
    chk("t5_done_at_e12", N*W'(log_d[12]), N*W'(1));

    // start held across DONE
    for (int i = 0; i < NN; i++) wr(1'b0, i, fl[i]);
    q0 = e0_q.size();
    cnt_v = valid_total;
    start = 1'b1;
    for (int i = 0; i < 40; i++) cyc();
    start = 1'b0;
    for (int i = 0; i < 40 && model_busy(); i++) cyc();
    cyc();
    chk("t6_stream_count", N*W'(e0_q.size() - q0), N*W'(3));
    if (e0_q.size() - q0 == 3) begin
      chk("t6_gap1", N*W'(e0_q[q0 + 1] - e0_q[q0]), N*W'(TOT + 2));
      chk("t6_gap2", N*W'(e0_q[q0 + 2] - e0_q[q0 + 1]), N*W'(TOT + 2));
    end
    chk("t6_valid_total", N*W'(valid_total - cnt_v), N*W'(33));

    // Randomized writes and starts, including during streams
    for (int i = 0; i < 400; i++) begin
      wr_en   = 1'($urandom_range(0, 1));
      wr_sel  = 1'($urandom_range(0, 1));
      wr_addr = AW'($urandom_range(0, 15));
      wr_data = $urandom;
      start   = ($urandom_range(0, 7) == 0);
      cyc();
    end
    wr_en = 1'b0; start = 1'b0;
    for (int i = 0; i < 40 && model_busy(); i++) cyc();
    cyc(); cyc();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
